// File: rtl/pipeline_stall_controller_pkg.sv
// pipeline_stall_controller_pkg: shared state encoding and control-word types for the stall controller
package pipeline_stall_controller_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;
    typedef struct packed {
        logic freeze_pc;
        logic bubble_id_ex;
        logic flush_if_id;
        logic flush_id_ex;
        logic freeze_all;
        logic mem_timeout;
    } ctrl_t;
    localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/pipeline_stall_controller_sat.sv
// sat_counter: W-bit up-counter that saturates at all-ones; i_clr wins over i_inc
// Ports: i_clk, i_rst_n (async low), i_inc, i_clr, o_q
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)               r_q <= '0;
        else if (i_clr)             r_q <= '0;
        else if (i_inc && !(&r_q))  r_q <= r_q + 1'b1;
    assign o_q = r_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: prioritised freeze/flush sequencer with SRAM watchdog and perf counters
// Inputs : i_clk, i_rst_n, i_hazard_detected, i_branch_taken, i_mem_req, i_mem_ready, i_err_clr, i_cnt_clr
// Outputs: o_freeze_pc, o_bubble_id_ex, o_flush_if_id, o_flush_id_ex, o_freeze_all, o_mem_timeout,
//          o_hazard_cnt, o_memwait_cnt, o_flush_cnt
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hazard_detected,
    input  logic             i_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    input  logic             i_err_clr,
    input  logic             i_cnt_clr,
    output logic             o_freeze_pc,
    output logic             o_bubble_id_ex,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_freeze_all,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_hazard_cnt,
    output logic [CNT_W-1:0] o_memwait_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    state_t     r_state, w_next_state;
    logic [7:0] r_wait_cnt, w_next_wait;
    ctrl_t      w_ctrl;
    logic       w_mem_stall;

    assign w_mem_stall = i_mem_req & ~i_mem_ready;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
        end

    // r_wait_cnt holds the number of stalled cycles already elapsed, so the
    // RUN cycle that first stalls counts as one and ERROR follows exactly
    // MAX_WAIT stalled cycles.
    always_comb begin
        w_ctrl       = CTRL_NOP;
        w_next_state = r_state;
        w_next_wait  = '0;
        if (r_state == ERROR) begin
            w_ctrl.freeze_all  = 1'b1;
            w_ctrl.mem_timeout = 1'b1;
            w_next_state       = i_err_clr ? RUN : ERROR;
        end else if (r_state == MEM_WAIT && !i_mem_ready) begin
            // mem_req dropping here is illegal; the wait is held regardless
            w_ctrl.freeze_all = 1'b1;
            w_next_wait       = r_wait_cnt + 8'd1;
            w_next_state      = (r_wait_cnt == 8'(MAX_WAIT - 1)) ? ERROR : MEM_WAIT;
        end else if (r_state == RUN && w_mem_stall) begin
            w_ctrl.freeze_all = 1'b1;
            w_next_wait       = 8'd1;
            w_next_state      = MEM_WAIT;
        end else begin
            // branch flush kills the hazarding instruction, so hazard is ignored
            w_next_state        = RUN;
            w_ctrl.flush_if_id  = i_branch_taken;
            w_ctrl.flush_id_ex  = i_branch_taken;
            w_ctrl.freeze_pc    = ~i_branch_taken & i_hazard_detected;
            w_ctrl.bubble_id_ex = ~i_branch_taken & i_hazard_detected;
        end
    end

    assign o_freeze_pc    = w_ctrl.freeze_pc;
    assign o_bubble_id_ex = w_ctrl.bubble_id_ex;
    assign o_flush_if_id  = w_ctrl.flush_if_id;
    assign o_flush_id_ex  = w_ctrl.flush_id_ex;
    assign o_freeze_all   = w_ctrl.freeze_all;
    assign o_mem_timeout  = w_ctrl.mem_timeout;

    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_ctrl.bubble_id_ex),
        .i_clr(i_cnt_clr), .o_q(o_hazard_cnt)
    );
    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_ctrl.freeze_all & ~w_ctrl.mem_timeout),
        .i_clr(i_cnt_clr), .o_q(o_memwait_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_ctrl.flush_if_id),
        .i_clr(i_cnt_clr), .o_q(o_flush_cnt)
    );
endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central freeze/flush sequencer for the 5-stage ARM-subset pipeline (IF, ID, EXE, MEM, WB).
- Merges three stall/flush sources into per-stage control: the ID-stage hazard flag, the EXE-stage branch-taken flag, and the MEM-stage SRAM handshake.
- Enforces a fixed priority among them and runs a wait-state watchdog on the SRAM.
- Keeps saturating performance counters.
- Sits between the hazard detection unit, the EXE stage, the SRAM controller and the pipeline registers.

Parameters:
- MAX_WAIT, 16, maximum consecutive cycles MEM may wait on mem_ready before a timeout; legal range 2..255.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hazard_detected  in  1  RAW hazard flag from the hazard detection unit.
- branch_taken  in  1  EXE stage resolved a taken branch this cycle.
- mem_req  in  1  MEM stage holds a load or store (MEM_R_EN | MEM_W_EN).
- mem_ready  in  1  SRAM controller completion strobe.
- err_clr  in  1  one-cycle pulse that leaves ERROR.
- cnt_clr  in  1  synchronous clear of all counters.
- freeze_pc  out  1  hold PC and IF/ID register.
- bubble_id_ex  out  1  load a NOP (all enables zero) into ID/EX.
- flush_if_id  out  1  clear IF/ID to a NOP.
- flush_id_ex  out  1  clear ID/EX to a NOP.
- freeze_all  out  1  hold every pipeline register, including PC.
- mem_timeout  out  1  sticky error flag; high while in ERROR.
- hazard_cnt  out  CNT_W  count of hazard bubble cycles.
- memwait_cnt  out  CNT_W  count of SRAM wait cycles.
- flush_cnt  out  CNT_W  count of branch flush events.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: state=RUN, wait_cnt=0, all counters 0, mem_timeout=0. All combinational outputs evaluate to 0 with idle inputs.
- Control outputs are combinational, so they act in the same cycle as their inputs. State, wait_cnt and counters are registered.
- Define mem_stall = mem_req & ~mem_ready.
- States:
  - RUN to MEM_WAIT when mem_stall.
  - MEM_WAIT to RUN when mem_ready.
  - MEM_WAIT to ERROR when wait_cnt==MAX_WAIT-1 and mem_ready=0.
  - ERROR to RUN only on err_clr.
  - A mem_req that drops during MEM_WAIT is illegal. The block holds MEM_WAIT regardless.
- wait_cnt:
  - Cleared in RUN.
  - Increments each cycle in MEM_WAIT.
  - Evaluated every cycle; the timeout fires after exactly MAX_WAIT stalled cycles.
- Output priority, highest first:
  1. ERROR: freeze_all=1, mem_timeout=1, all other controls 0.
  2. Memory wait (mem_stall in RUN, or MEM_WAIT with mem_ready=0): freeze_all=1 only. The branch and hazard signals are held, not lost, because EXE and ID are frozen too.
  3. branch_taken: flush_if_id=1 and flush_id_ex=1. Hazard is ignored, because the hazarding instruction is being flushed.
  4. hazard_detected: freeze_pc=1 and bubble_id_ex=1.
  5. Otherwise: all controls 0.
- In the cycle mem_ready arrives in MEM_WAIT, freeze_all=0 and lower priorities apply normally.
- Counters (saturate at all-ones, never wrap):
  - hazard_cnt +1 per cycle bubble_id_ex=1.
  - memwait_cnt +1 per cycle freeze_all=1 outside ERROR.
  - flush_cnt +1 per cycle flush_if_id=1.
- cnt_clr takes precedence over any increment in the same cycle.
- Reset mid-wait: returns to RUN immediately; counters and the sticky flag are cleared.

Decomposition:
- Shared pipeline package holds:
  - state encoding: RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2;
  - NOP control-word constant used for bubbles and flushes.
- One natural sub-module, sat_counter (parameter W; inputs inc and clr; output q), instantiated three times.

Test Plan:
- Reset with all inputs 0 -> every output 0 and every counter 0; assert rst_n low mid-MEM_WAIT -> RUN next observed cycle, counters 0.
- hazard_detected=1 for 2 cycles -> freeze_pc=bubble_id_ex=1 in both cycles, hazard_cnt=2, flush_cnt=0.
- branch_taken=1 and hazard_detected=1 in the same cycle -> flush_if_id=flush_id_ex=1, bubble_id_ex=0, flush_cnt=1, hazard_cnt=0.
- mem_req=1 with mem_ready arriving on the 5th cycle and branch_taken held high throughout -> freeze_all=1 for 4 cycles then 0, flush asserted on cycle 5, memwait_cnt=4, flush_cnt=1.
- MAX_WAIT=4 with mem_req=1 and mem_ready=0 -> ERROR after 4 wait cycles, mem_timeout=1 and freeze_all=1 held; err_clr pulse -> RUN next cycle, mem_timeout=0.
- CNT_W=4 with hazard held for 20 cycles -> hazard_cnt saturates at 15; cnt_clr pulse asserted together with an active hazard -> hazard_cnt=0 the following cycle.
